// File: rtl/sff_preset_driver.sv
// rtl/sff_preset_driver.sv - initiator for a preset-able 4-bit latch bank with readback check and retry
module sff_preset_driver #(
  parameter int unsigned    SETUP_CYC  = 1,
  parameter int unsigned    PULSE_CYC  = 2,
  parameter int unsigned    HOLD_CYC   = 1,
  parameter int unsigned    MAX_RETRY  = 2,
  parameter logic [3:0]     RESET_CODE = 4'b1101,
  parameter logic [3:0]     SET_CODE   = 4'b0110
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       lat_en,
  output logic       lat_reset,
  output logic       lat_set,
  output logic [3:0] lat_cs,
  input  logic [3:0] lat_ns,
  output logic       done,
  output logic       err,
  output logic [3:0] rd_data,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {IDLE, DRIVE, OPEN, CLOSE, CHECK, RESP} state_t;

  // Counters are loaded with N-1 so a window of N cycles ends when the count reaches zero.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] op;
  logic [3:0] expv;
  logic [3:0] cmd_code;

  // Value the bank is expected to hold once the incoming command has been applied.
  always_comb begin
    cmd_code = cmd_data;
    case (cmd_op)
      2'b01:   cmd_code = RESET_CODE;
      2'b10:   cmd_code = SET_CODE;
      default: cmd_code = cmd_data;
    endcase
  end

  // Command sequencer: drive lines, pulse enable, hold, then verify readback and retry on mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      op        <= 2'b00;
      expv      <= 4'd0;
      cmd_ready <= 1'b0;
      lat_en    <= 1'b0;
      lat_reset <= 1'b0;
      lat_set   <= 1'b0;
      lat_cs    <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= 4'd0;
      retry_cnt <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          lat_en    <= 1'b0;
          lat_reset <= 1'b0;
          lat_set   <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op        <= cmd_op;
            expv      <= cmd_code;
            retry_cnt <= 4'd0;
            if (cmd_op == 2'b00) begin
              state <= CHECK;
            end else begin
              state     <= DRIVE;
              cnt       <= SETUP_LD;
              lat_cs    <= cmd_code;
              lat_reset <= (cmd_op == 2'b01);
              lat_set   <= (cmd_op == 2'b10);
            end
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            state  <= OPEN;
            cnt    <= PULSE_LD;
            lat_en <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OPEN: begin
          if (cnt == 8'd0) begin
            state  <= CLOSE;
            cnt    <= HOLD_LD;
            lat_en <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CLOSE: begin
          if (cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          if (op != 2'b00 && lat_ns != expv && retry_cnt < RETRY_MAX) begin
            // Lines are still driven from the previous attempt, so the retry replays the full window.
            retry_cnt <= retry_cnt + 4'd1;
            state     <= DRIVE;
            cnt       <= SETUP_LD;
          end else begin
            state     <= RESP;
            done      <= 1'b1;
            err       <= (op != 2'b00) && (lat_ns != expv);
            rd_data   <= lat_ns;
            lat_reset <= 1'b0;
            lat_set   <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sff_preset_driver.sv
// tb/tb_sff_preset_driver.sv - table-driven scoreboard bench for sff_preset_driver
module tb_sff_preset_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic       lat_en, lat_reset, lat_set;
  logic [3:0] lat_cs;
  logic [3:0] lat_ns;
  logic       done, err;
  logic [3:0] rd_data, retry_cnt;

  logic [3:0] bank = 4'd0;
  logic       stuck = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         en_rises = 0;
  int         pre_cycles = 0;
  logic       en_q = 1'b0;
  logic [5:0] lines_q = 6'd0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic       stuck;
    logic       b2b;
    logic [3:0] rd;
    logic       err;
    logic [3:0] retry;
    int         lat;
    int         pulses;
    int         pre;
  } vec_t;

  typedef struct {
    logic [3:0] rd;
    logic       err;
    logic [3:0] retry;
    int         done_cyc;
    int         en_base;
    int         pulses;
    int         pre_base;
    int         pre;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  sff_preset_driver dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .lat_en(lat_en), .lat_reset(lat_reset),
    .lat_set(lat_set), .lat_cs(lat_cs), .lat_ns(lat_ns), .done(done), .err(err),
    .rd_data(rd_data), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural latch bank: captures while enabled, presets win over data, bit 0 optionally stuck low.
  always @(posedge clk) begin
    if (lat_en) bank <= (lat_reset ? 4'b1101 : lat_set ? 4'b0110 : lat_cs) & {3'b111, ~stuck};
  end
  assign lat_ns = bank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol monitor and scoreboard consumer.
  always @(negedge clk) begin
    en_q    <= lat_en;
    lines_q <= {lat_cs, lat_reset, lat_set};
    if (reset_n) begin
      chk("preset_exclusive", {31'd0, lat_reset & lat_set}, 32'd0);
      if (lat_en && !en_q) begin
        en_rises <= en_rises + 1;
        chk("lines_stable_at_en", {26'd0, lat_cs, lat_reset, lat_set}, {26'd0, lines_q});
      end
      if (lat_reset || lat_set) pre_cycles <= pre_cycles + 1;
      if (err && !done) chk("err_without_done", 32'd1, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("rd_data", {28'd0, rd_data}, {28'd0, mon_e.rd});
          chk("err", {31'd0, err}, {31'd0, mon_e.err});
          chk("retry_cnt", {28'd0, retry_cnt}, {28'd0, mon_e.retry});
          chk("en_pulses", en_rises - mon_e.en_base, mon_e.pulses);
          chk("preset_cycles", pre_cycles - mon_e.pre_base, mon_e.pre);
        end
      end
    end
  end

  task automatic issue(input vec_t v, output int acc);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    acc       = cyc;
    e.rd       = v.rd;
    e.err      = v.err;
    e.retry    = v.retry;
    e.done_cyc = acc + v.lat;
    e.en_base  = en_rises;
    e.pulses   = v.pulses;
    e.pre_base = pre_cycles;
    e.pre      = v.pre;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int   acc, prev_acc, prev_lat, n;
    vec_t hv;

    //          op     data   stk   b2b   rd     err   rty   lat pul pre
    vecs[0] = '{2'b01, 4'h0, 1'b0, 1'b0, 4'hD, 1'b0, 4'd0, 6,  1, 5};
    vecs[1] = '{2'b11, 4'hA, 1'b0, 1'b0, 4'hA, 1'b0, 4'd0, 6,  1, 0};
    vecs[2] = '{2'b10, 4'h0, 1'b0, 1'b1, 4'h6, 1'b0, 4'd0, 6,  1, 5};
    vecs[3] = '{2'b00, 4'h0, 1'b0, 1'b0, 4'h6, 1'b0, 4'd0, 2,  0, 0};
    vecs[4] = '{2'b11, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 4'd2, 16, 3, 0};
    vecs[5] = '{2'b11, 4'hF, 1'b1, 1'b0, 4'hE, 1'b1, 4'd2, 16, 3, 0};
    vecs[6] = '{2'b01, 4'h0, 1'b1, 1'b0, 4'hC, 1'b1, 4'd2, 16, 3, 15};
    vecs[7] = '{2'b11, 4'h7, 1'b0, 1'b0, 4'h7, 1'b0, 4'd0, 6,  1, 0};
    vecs[8] = '{2'b00, 4'h0, 1'b0, 1'b0, 4'h7, 1'b0, 4'd0, 2,  0, 0};

    // Reset held with a command pending: everything low, nothing accepted.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", {11'd0, cmd_ready, lat_en, lat_reset, lat_set, lat_cs, done, err, rd_data, retry_cnt}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("no_accept_in_reset", {30'd0, cmd_ready, lat_reset}, 32'd2);

    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 9; i++) begin
      if (!vecs[i].b2b) wait_idle();
      stuck = vecs[i].stuck;
      issue(vecs[i], acc);
      if (vecs[i].b2b) chk("b2b_accept_cycle", acc, prev_acc + prev_lat + 1);
      prev_acc = acc;
      prev_lat = vecs[i].lat;
    end
    wait_idle();

    // Readback with a stray cmd_valid pulse while busy.
    hv = '{2'b00, 4'h0, 1'b0, 1'b0, 4'h7, 1'b0, 4'd0, 2, 0, 0};
    issue(hv, acc);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 4'h3;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("stray_valid_ignored", {28'd0, bank}, 32'h7);

    // Reset during OPEN aborts without a response.
    hv = '{2'b11, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 4'd0, 6, 1, 0};
    issue(hv, acc);
    n = 0;
    while (!lat_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_open", {31'd0, lat_en}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_abort", {24'd0, lat_en, lat_reset, lat_set, done, err, retry_cnt[2:0]}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
    issue(vecs[0], acc);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sff_preset_driver.md
Name: sff_preset_driver

Overview:
- Initiator side of the preset-able 4-bit state-latch interface (latch enable, reset-preset, set-preset, data-in, readback).
- Accepts load/preset/readback commands over a valid/ready handshake.
- Sequences setup, enable pulse and hold windows for the latch bank, then checks the readback against the expected value.
- Retries a failed load a bounded number of times and reports done or error; used by control FSMs that load state through a latch bank instead of directly.

Parameters:
- SETUP_CYC, 1, cycles the data/preset lines are driven with enable low before the pulse (1..255; 0 illegal)
- PULSE_CYC, 2, cycles the latch enable is held high (1..255; 0 illegal)
- HOLD_CYC, 1, cycles the lines stay driven after enable falls (1..255; 0 illegal)
- MAX_RETRY, 2, re-attempts after a readback mismatch (0..15)
- RESET_CODE, 4'b1101, value the bank takes under reset-preset
- SET_CODE, 4'b0110, value the bank takes under set-preset

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver idle, can accept
- cmd_op  in  2  00 readback, 01 reset-preset, 10 set-preset, 11 load cmd_data
- cmd_data  in  4  load value (used only for op 11)
- lat_en  out  1  latch enable to bank
- lat_reset  out  1  reset-preset request to bank
- lat_set  out  1  set-preset request to bank
- lat_cs  out  4  data to bank
- lat_ns  in  4  bank readback
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done on final mismatch
- rd_data  out  4  lat_ns sampled in the final CHECK; valid from the done cycle until the next accept
- retry_cnt  out  4  retries used by the current/last command

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - lat_en, lat_reset, lat_set, lat_cs, done, err, rd_data and retry_cnt all clear to 0 immediately, without waiting for a clock edge.
  - cmd_ready=1 from the first edge after release.
- States: IDLE, DRIVE, OPEN, CLOSE, CHECK, RESP. An 8-bit down-counter times DRIVE, OPEN and CLOSE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready (cycle T):
  - Latch op and expected value: 01->RESET_CODE, 10->SET_CODE, 11->cmd_data.
  - Clear retry_cnt.
  - op 00 goes to CHECK; all other ops go to DRIVE.
- cmd_ready=0 in every state other than IDLE. cmd_valid is ignored while busy and no command is queued.
- DRIVE (SETUP_CYC cycles): lat_en=0; lat_cs=expected; lat_reset=1 only for op 01; lat_set=1 only for op 10.
- OPEN (PULSE_CYC cycles): as DRIVE, but lat_en=1.
- CLOSE (HOLD_CYC cycles): lat_en=0; lat_cs, lat_reset and lat_set unchanged.
- CHECK (1 cycle): sample lat_ns.
  - op 00: go to RESP with no error.
  - Match with expected: go to RESP with err=0.
  - Mismatch and retry_cnt<MAX_RETRY: increment retry_cnt and go to DRIVE (full sequence repeated).
  - Mismatch and retry_cnt==MAX_RETRY: go to RESP with err=1.
- RESP (1 cycle): done=1, err as decided in CHECK, rd_data=sample; then IDLE.
- On entering IDLE: lat_reset=lat_set=0. lat_cs keeps its last value.
- Latency with defaults:
  - Preset/load: accept T, DRIVE T+1, OPEN T+2..T+3, CLOSE T+4, CHECK T+5, done T+6, cmd_ready T+7.
  - Readback (op 00): CHECK T+1, done T+2. lat_en never pulses.
- Each retry adds SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- lat_reset and lat_set are never high together. lat_en only rises while lat_cs and the preset lines are already stable.
- Reset mid-operation: lat_en drops asynchronously; no done or err is issued for the aborted command.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with cmd_valid=1 -> all outputs 0 throughout, cmd_ready=1 after release, no command accepted during reset.
- op 01, behavioural latch model on bank -> lat_reset high T+1..T+5, lat_en high T+2..T+3, done T+6, rd_data=1101, err=0, retry_cnt=0.
- op 11 with cmd_data=1010, then op 10 back-to-back -> done with rd_data=1010; the second command is accepted at T+7, done with rd_data=0110, and lat_set never overlaps lat_reset.
- Latch model with ns[0] stuck at 0, op 11 with cmd_data=0001 -> exactly 3 lat_en pulses, done+err at T+6+2*5=T+16, rd_data=0000, retry_cnt=2.
- reset_n asserted during OPEN -> lat_en falls with no clock edge; no done/err; after release cmd_ready=1 and a new op 01 completes normally.
- Latch model holding 0110, op 00 -> done at T+2, rd_data=0110, lat_en stays 0; cmd_valid toggled at T+1 is ignored.
